bus_dest_regfile: RTL and testbench
===================================

Name: bus_dest_regfile

Overview:
- Destination end of the CPU's shared 32-bit bus. Captures the bus value into the storage element named by a 5-bit destination code. Uses the same code space as the bus source select: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = Z_HI, 19 = Z_LO, 20 = PC, 21 = MDR, 22 = In_Port, 23 = C_Sign_Extended.
- Holds R0-R15, HI, LO, Z (64-bit), PC and MDR.
- Presents every stored value continuously so it can be driven back onto the bus.

Parameters:
- DATA_W, 32, width of bus and of every register.
- PC_RESET, 32'h0000_0000, PC value after reset.
- PC_STEP, 1, amount added to PC on inc_pc.

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- bus_in  in  DATA_W  current bus value
- dest_sel  in  5  destination code, same encoding as the bus source select
- dest_we  in  1  write bus_in into the dest_sel target at this edge
- inc_pc  in  1  advance PC by PC_STEP
- z_in  in  1  load Z from the ALU result
- alu_result  in  2*DATA_W  ALU output; [63:32] goes to Z_HI, [31:0] goes to Z_LO
- mdr_read  in  1  load MDR from memory data
- mem_data_in  in  DATA_W  memory read data
- r0_out..r15_out  out  DATA_W each  register contents
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out  out  DATA_W each  register contents
- illegal_dest  out  1  one-cycle flag: write attempted to a non-writable code
- err_sticky  out  1  set by any illegal write; cleared only by reset

Behaviour:
- Reset (clear_n = 0, asynchronous, takes effect immediately regardless of clock):
  - All R, HI, LO, Z and MDR go to 0.
  - PC goes to PC_RESET.
  - illegal_dest = 0, err_sticky = 0.
  - Reset asserted mid-write aborts the write; no partial update.
- Writes occur only on the rising clock edge.
  - The new value appears on the corresponding *_out after that edge: 1-cycle latency.
  - Outputs are direct register outputs, with no combinational path from bus_in.
  - No bypass: a same-cycle read of a target being written returns the old value.
- dest_we = 1 with a writable code:
  - 0-15 writes R[dest_sel].
  - 16 writes HI; 17 writes LO; 20 writes PC; 21 writes MDR.
  - R0 is an ordinary register, not hardwired to zero.
  - Exactly one target changes per edge from the bus.
- dest_we = 1 with a non-writable code (18, 19, 22, 23, 24-31):
  - No storage element changes.
  - illegal_dest = 1 for exactly the following cycle; err_sticky is set.
- illegal_dest is 0 on any edge without an illegal write.
  - Back-to-back illegal writes hold it at 1 continuously.
- dest_we = 0: dest_sel is ignored and no bus write occurs.
- PC priority (highest first):
  1. bus write to code 20
  2. inc_pc, giving PC + PC_STEP modulo 2^DATA_W, so 32'hFFFF_FFFF wraps to 0 when PC_STEP = 1
  3. hold
- MDR priority (highest first):
  1. mdr_read, loads mem_data_in
  2. bus write to code 21
  3. hold
- Z:
  - z_in = 1 loads both halves from alu_result in the same edge; otherwise Z holds.
  - Z is never bus-writable.
- Independent controls may coincide in one cycle, and each takes effect:
  - e.g. dest_we to R3, inc_pc and z_in all in one cycle update R3, PC and Z together.
- The block has no internal state beyond the registers and the two error flags.
- Widths: all data paths are DATA_W, except alu_result, which is 2*DATA_W.
- Every arithmetic result is truncated to DATA_W.

Test Plan:
- Reset, then write: clear_n low → all outputs 0, pc_out = PC_RESET. Then dest_we = 1, dest_sel = 5, bus_in = 32'hDEAD_BEEF → r5_out = 32'hDEAD_BEEF one edge later; every other output unchanged.
- Sweep writable codes 0-17, 20, 21 with bus_in = code*32'h0101_0101 → each target holds its own pattern; r0_out = 0 until code 0 is written, then 0.
- Illegal write: dest_sel = 19, bus_in = 32'h1234 → zlo_out unchanged, illegal_dest high for 1 cycle, err_sticky stays high afterwards. Repeat with codes 22 and 31 → same response.
- PC priority:
  - pc = 32'hFFFF_FFFF, inc_pc = 1 → pc_out = 0.
  - inc_pc = 1 together with a bus write to code 20 of 32'h40 → pc_out = 32'h40.
- MDR priority and Z load:
  - mdr_read = 1, mem_data_in = 32'hAAAA_0001, together with a bus write to code 21 of 32'h5555 → mdr_out = 32'hAAAA_0001.
  - z_in with alu_result = 64'h0000_0001_8000_0000 → zhi_out = 1, zlo_out = 32'h8000_0000.
- Asynchronous reset mid-cycle: after loading R7 = 32'hFFFF_FFFF, assert clear_n between edges → r7_out = 0 immediately, err_sticky = 0, and a pending dest_we write at the next edge while in reset is ignored.

Source files
------------

// File: rtl/bus_dest_regfile.sv
// Destination end of the shared CPU bus: R0-R15, HI, LO, Z, PC, MDR and the illegal-write flags.
// Latency: 1 cycle from the capturing edge to the *_out ports. All outputs come straight from flops.
// Backpressure: none. Every enabled write lands at the edge. Writes to non-writable codes are dropped and flagged.
module bus_dest_regfile #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  PC_RESET = '0,
    parameter logic [DATA_W-1:0]  PC_STEP  = {{(DATA_W-1){1'b0}}, 1'b1}
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic [DATA_W-1:0]     bus_in,
    input  logic [4:0]            dest_sel,
    input  logic                  dest_we,
    input  logic                  inc_pc,
    input  logic                  z_in,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic                  mdr_read,
    input  logic [DATA_W-1:0]     mem_data_in,
    output logic [DATA_W-1:0]     r0_out,
    output logic [DATA_W-1:0]     r1_out,
    output logic [DATA_W-1:0]     r2_out,
    output logic [DATA_W-1:0]     r3_out,
    output logic [DATA_W-1:0]     r4_out,
    output logic [DATA_W-1:0]     r5_out,
    output logic [DATA_W-1:0]     r6_out,
    output logic [DATA_W-1:0]     r7_out,
    output logic [DATA_W-1:0]     r8_out,
    output logic [DATA_W-1:0]     r9_out,
    output logic [DATA_W-1:0]     r10_out,
    output logic [DATA_W-1:0]     r11_out,
    output logic [DATA_W-1:0]     r12_out,
    output logic [DATA_W-1:0]     r13_out,
    output logic [DATA_W-1:0]     r14_out,
    output logic [DATA_W-1:0]     r15_out,
    output logic [DATA_W-1:0]     hi_out,
    output logic [DATA_W-1:0]     lo_out,
    output logic [DATA_W-1:0]     zhi_out,
    output logic [DATA_W-1:0]     zlo_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     mdr_out,
    output logic                  illegal_dest,
    output logic                  err_sticky
);

    localparam logic [4:0] CODE_HI  = 5'd16;
    localparam logic [4:0] CODE_LO  = 5'd17;
    localparam logic [4:0] CODE_PC  = 5'd20;
    localparam logic [4:0] CODE_MDR = 5'd21;

    logic [DATA_W-1:0] r_q [16];
    logic [DATA_W-1:0] r_d [16];
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
    logic [DATA_W-1:0] pc_q, pc_d, mdr_q, mdr_d;
    logic              illegal_q, illegal_d;
    logic              err_q, err_d;

    // Next-state decode. Statement order sets priority: the bus write to PC overrides inc_pc,
    // and mdr_read overrides a bus write to MDR.
    always_comb begin
        r_d       = r_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        zhi_d     = zhi_q;
        zlo_d     = zlo_q;
        pc_d      = pc_q;
        mdr_d     = mdr_q;
        illegal_d = 1'b0;

        if (inc_pc) begin
            pc_d = pc_q + PC_STEP;
        end

        if (dest_we) begin
            if (dest_sel < 5'd16) begin
                r_d[dest_sel[3:0]] = bus_in;
            end else begin
                case (dest_sel)
                    CODE_HI:  hi_d      = bus_in;
                    CODE_LO:  lo_d      = bus_in;
                    CODE_PC:  pc_d      = bus_in;
                    CODE_MDR: mdr_d     = bus_in;
                    default:  illegal_d = 1'b1;
                endcase
            end
        end

        if (mdr_read) begin
            mdr_d = mem_data_in;
        end

        if (z_in) begin
            zhi_d = alu_result[2*DATA_W-1:DATA_W];
            zlo_d = alu_result[DATA_W-1:0];
        end

        err_d = err_q | illegal_d;
    end

    // State registers. Reset is asynchronous, so a write pending during reset is dropped entirely.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 16; i++) begin
                r_q[i] <= '0;
            end
            hi_q      <= '0;
            lo_q      <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            pc_q      <= PC_RESET;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            r_q       <= r_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zhi_q     <= zhi_d;
            zlo_q     <= zlo_d;
            pc_q      <= pc_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
        end
    end

    assign r0_out       = r_q[0];
    assign r1_out       = r_q[1];
    assign r2_out       = r_q[2];
    assign r3_out       = r_q[3];
    assign r4_out       = r_q[4];
    assign r5_out       = r_q[5];
    assign r6_out       = r_q[6];
    assign r7_out       = r_q[7];
    assign r8_out       = r_q[8];
    assign r9_out       = r_q[9];
    assign r10_out      = r_q[10];
    assign r11_out      = r_q[11];
    assign r12_out      = r_q[12];
    assign r13_out      = r_q[13];
    assign r14_out      = r_q[14];
    assign r15_out      = r_q[15];
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;
    assign zhi_out      = zhi_q;
    assign zlo_out      = zlo_q;
    assign pc_out       = pc_q;
    assign mdr_out      = mdr_q;
    assign illegal_dest = illegal_q;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_bus_dest_regfile.sv
// Bench for bus_dest_regfile: a code-indexed storage model checked against the DUT on every falling edge,
// plus literal expectations from directed vectors.
// Inputs change 1 time unit after each rising edge. Outputs are sampled on falling edges or mid-cycle.
module tb_bus_dest_regfile;

    logic         clock = 1'b0;
    logic         clear_n;
    logic [31:0]  bus_in;
    logic [4:0]   dest_sel;
    logic         dest_we;
    logic         inc_pc;
    logic         z_in;
    logic [63:0]  alu_result;
    logic         mdr_read;
    logic [31:0]  mem_data_in;
    logic [31:0]  r_out [16];
    logic [31:0]  hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out;
    logic         illegal_dest, err_sticky;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bus_dest_regfile dut (
        .clock(clock), .clear_n(clear_n), .bus_in(bus_in), .dest_sel(dest_sel),
        .dest_we(dest_we), .inc_pc(inc_pc), .z_in(z_in), .alu_result(alu_result),
        .mdr_read(mdr_read), .mem_data_in(mem_data_in),
        .r0_out(r_out[0]), .r1_out(r_out[1]), .r2_out(r_out[2]), .r3_out(r_out[3]),
        .r4_out(r_out[4]), .r5_out(r_out[5]), .r6_out(r_out[6]), .r7_out(r_out[7]),
        .r8_out(r_out[8]), .r9_out(r_out[9]), .r10_out(r_out[10]), .r11_out(r_out[11]),
        .r12_out(r_out[12]), .r13_out(r_out[13]), .r14_out(r_out[14]), .r15_out(r_out[15]),
        .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out), .zlo_out(zlo_out),
        .pc_out(pc_out), .mdr_out(mdr_out), .illegal_dest(illegal_dest), .err_sticky(err_sticky)
    );

    // Reference model: one 32-bit slot per destination code (18/19 hold Z_HI/Z_LO).
    logic [31:0] m_store [32];
    logic        m_ill;
    logic        m_err;

    function automatic bit bus_writable(input logic [4:0] code);
        return (code < 5'd16) || (code == 5'd16) || (code == 5'd17) || (code == 5'd20) || (code == 5'd21);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model update, following the written rules for each storage element.
    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 32; i++) m_store[i] <= 32'h0;
            m_ill <= 1'b0;
            m_err <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (dest_we && dest_sel == 5'(i)) m_store[i] <= bus_in;
            if (dest_we && dest_sel == 5'd16) m_store[16] <= bus_in;
            if (dest_we && dest_sel == 5'd17) m_store[17] <= bus_in;
            if (dest_we && dest_sel == 5'd20)  m_store[20] <= bus_in;
            else if (inc_pc)                   m_store[20] <= m_store[20] + 32'd1;
            if (mdr_read)                              m_store[21] <= mem_data_in;
            else if (dest_we && dest_sel == 5'd21)     m_store[21] <= bus_in;
            if (z_in) begin
                m_store[18] <= alu_result[63:32];
                m_store[19] <= alu_result[31:0];
            end
            m_ill <= dest_we && !bus_writable(dest_sel);
            m_err <= m_err || (dest_we && !bus_writable(dest_sel));
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 16; i++) check($sformatf("model r%0d", i), r_out[i], m_store[i]);
        check("model hi",  hi_out,  m_store[16]);
        check("model lo",  lo_out,  m_store[17]);
        check("model zhi", zhi_out, m_store[18]);
        check("model zlo", zlo_out, m_store[19]);
        check("model pc",  pc_out,  m_store[20]);
        check("model mdr", mdr_out, m_store[21]);
        check("model illegal_dest", {31'b0, illegal_dest}, {31'b0, m_ill});
        check("model err_sticky",   {31'b0, err_sticky},   {31'b0, m_err});
    end

    task automatic idle();
        bus_in = '0; dest_sel = '0; dest_we = 1'b0; inc_pc = 1'b0;
        z_in = 1'b0; alu_result = '0; mdr_read = 1'b0; mem_data_in = '0;
    endtask

    // Apply the currently driven inputs for one rising edge, then return to idle.
    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic wr(input logic [4:0] code, input logic [31:0] data);
        dest_we = 1'b1; dest_sel = code; bus_in = data;
        tick();
    endtask

    initial begin
        idle();
        clear_n = 1'b1;
        #1 clear_n = 1'b0;
        #7;
        check("reset r5", r_out[5], 32'h0);
        check("reset pc", pc_out, 32'h0);
        check("reset err", {31'b0, err_sticky}, 32'h0);
        #4 clear_n = 1'b1;
        tick();

        // Single write to R5
        wr(5'd5, 32'hDEAD_BEEF);
        check("r5 write", r_out[5], 32'hDEAD_BEEF);
        check("r4 untouched", r_out[4], 32'h0);

        // Sweep every writable code with code*0x01010101
        for (int c = 0; c < 22; c++) begin
            if (c == 18 || c == 19) continue;
            wr(5'(c), 32'(c) * 32'h0101_0101);
        end
        check("sweep r0", r_out[0], 32'h0);
        check("sweep r9", r_out[9], 32'h0909_0909);
        check("sweep hi", hi_out, 32'h1010_1010);
        check("sweep lo", lo_out, 32'h1111_1111);
        check("sweep pc", pc_out, 32'h1414_1414);
        check("sweep mdr", mdr_out, 32'h1515_1515);

        // Illegal writes: single, then two back to back
        wr(5'd19, 32'h1234);
        check("illegal flag", {31'b0, illegal_dest}, 32'h1);
        check("illegal zlo", zlo_out, 32'h0);
        tick();
        check("illegal drop", {31'b0, illegal_dest}, 32'h0);
        check("err sticky", {31'b0, err_sticky}, 32'h1);
        wr(5'd22, 32'h1234);
        wr(5'd31, 32'h1234);
        check("illegal b2b", {31'b0, illegal_dest}, 32'h1);

        // PC wrap and PC priority
        wr(5'd20, 32'hFFFF_FFFF);
        inc_pc = 1'b1;
        tick();
        check("pc wrap", pc_out, 32'h0);
        inc_pc = 1'b1; dest_we = 1'b1; dest_sel = 5'd20; bus_in = 32'h40;
        tick();
        check("pc bus over inc", pc_out, 32'h40);

        // MDR priority and Z load
        mdr_read = 1'b1; mem_data_in = 32'hAAAA_0001;
        dest_we = 1'b1; dest_sel = 5'd21; bus_in = 32'h5555;
        tick();
        check("mdr priority", mdr_out, 32'hAAAA_0001);
        z_in = 1'b1; alu_result = 64'h0000_0001_8000_0000;
        tick();
        check("zhi load", zhi_out, 32'h1);
        check("zlo load", zlo_out, 32'h8000_0000);

        // Coincident controls in one cycle
        dest_we = 1'b1; dest_sel = 5'd3; bus_in = 32'h3333_0003;
        inc_pc = 1'b1; z_in = 1'b1; alu_result = 64'h0000_0022_0000_0011;
        tick();
        check("coincide r3", r_out[3], 32'h3333_0003);
        check("coincide pc", pc_out, 32'h41);
        check("coincide zlo", zlo_out, 32'h11);

        // Asynchronous reset between edges, with a write pending
        wr(5'd7, 32'hFFFF_FFFF);
        check("r7 loaded", r_out[7], 32'hFFFF_FFFF);
        #1;
        dest_we = 1'b1; dest_sel = 5'd7; bus_in = 32'h7777_7777;
        #1 clear_n = 1'b0;
        #1;
        check("async r7", r_out[7], 32'h0);
        check("async err", {31'b0, err_sticky}, 32'h0);
        check("async pc", pc_out, 32'h0);
        @(posedge clock);
        #1;
        check("write in reset", r_out[7], 32'h0);
        idle();
        clear_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
